// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: instruction sequencer for one convolution tile on the 2D core.
// Each kernel position runs weight fetch, kernel load, activation fetch, execute,
// flush and output drain, and emits one registered 35-bit inst word per cycle.
// Optional feature macro: CORE_SEQ_ACC_EN. When it is defined, every kernel position
// writes psums to the same region (p_base + o) and accumulates for kij > 0. When it is
// undefined, each kernel position gets its own psum region.
//
// state   | meaning
// IDLE    | waiting for start; default word
// W_RD    | row weight words read from xmem (l0_wr trails each read by one cycle)
// W_KL    | col cycles of kernel load from L0
// A_RD    | len_nij activation words read from xmem (same trailing l0_wr)
// EXEC    | len_nij cycles of execute from L0
// FLUSH   | row+col cycles of default word while the array empties
// DRAIN   | ofifo reads when valid; psum write one cycle after each read (OS only)
// DONE    | one-cycle done pulse, then back to IDLE
`timescale 1ns/1ps
module core_seq_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [10:0] i_w_base,
  input  logic [10:0] i_a_base,
  input  logic [10:0] i_p_base,
  input  logic        i_ofifo_valid,
  output logic [34:0] o_inst,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_kij
);

  localparam int CNT_MAX = (len_nij > row + col) ? len_nij : row + col;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] W_RD_LAST  = CW'(row - 1);
  localparam logic [CW-1:0] W_KL_LAST  = CW'(col - 1);
  localparam logic [CW-1:0] NIJ_LAST   = CW'(len_nij - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(row + col - 1);
  localparam logic [CW-1:0] NIJ        = CW'(len_nij);
  localparam logic [3:0]    KIJ_LAST   = 4'(len_kij - 1);

  // All CEN/WEN high, every strobe low; bit 34 is replaced by the latched mode.
  localparam logic [34:0] DEFAULT_WORD = 35'h1800C0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_RD,
    S_W_KL,
    S_A_RD,
    S_EXEC,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   r_o;
  logic [CW-1:0]   w_o_nxt;
  logic [3:0]      r_kij;
  logic [3:0]      w_kij_nxt;
  logic            r_mode;
  logic            w_mode_nxt;
  logic [10:0]     r_w_base;
  logic [10:0]     r_a_base;
  logic [10:0]     r_p_base;
  logic [10:0]     w_w_base_nxt;
  logic [10:0]     w_a_base_nxt;
  logic [10:0]     w_p_base_nxt;
  logic [34:0]     r_inst;
  logic [34:0]     w_inst_nxt;
  logic            r_busy;
  logic            r_done;

  logic            w_load;
  logic            w_rd_nxt;
  logic            w_wr_nxt;
  logic            w_rd_cur;
  logic            w_xrd_cur;
  logic [CW-1:0]   w_wr_idx;
  logic [10:0]     w_waddr;
  logic [10:0]     w_aaddr;
  logic [10:0]     w_paddr;
  logic            w_acc;

  // The word on inst this cycle tells us whether a read is in flight, which
  // drives the one-cycle-delayed l0_wr and psum write strobes.
  assign w_rd_cur  = r_inst[6];
  assign w_xrd_cur = ~r_inst[19];
  assign w_wr_idx  = r_o - CW'(1);

  // Tile configuration is captured only on an accepted start.
  assign w_load       = (r_state == S_IDLE) && i_start;
  assign w_mode_nxt   = w_load ? i_mode   : r_mode;
  assign w_w_base_nxt = w_load ? i_w_base : r_w_base;
  assign w_a_base_nxt = w_load ? i_a_base : r_a_base;
  assign w_p_base_nxt = w_load ? i_p_base : r_p_base;

  // Address sums wrap modulo 2048 by truncation to 11 bits.
  assign w_waddr = w_w_base_nxt + 11'(w_kij_nxt * row) + 11'(w_cnt_nxt);
  assign w_aaddr = r_a_base + 11'(w_cnt_nxt);

`ifdef CORE_SEQ_ACC_EN
  assign w_paddr = r_p_base + 11'(w_wr_idx);
  assign w_acc   = (r_kij != 4'd0);
`else
  assign w_paddr = r_p_base + 11'(r_kij * len_nij) + 11'(w_wr_idx);
  assign w_acc   = 1'b0;
`endif

  // Next-state, phase counter, drain counter and kernel-position sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_o_nxt     = r_o;
    w_kij_nxt   = r_kij;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_W_RD;
          w_cnt_nxt   = '0;
          w_o_nxt     = '0;
          w_kij_nxt   = '0;
        end
      end
      S_W_RD: begin
        if (r_cnt == W_RD_LAST) begin
          w_state_nxt = S_W_KL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_W_KL: begin
        if (r_cnt == W_KL_LAST) begin
          w_state_nxt = S_A_RD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_A_RD: begin
        if (r_cnt == NIJ_LAST) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_EXEC: begin
        if (r_cnt == NIJ_LAST) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
          w_rd_nxt    = i_ofifo_valid;
          w_o_nxt     = i_ofifo_valid ? CW'(1) : '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        // r_o counts reads already issued; the write for the read now on inst
        // goes out with the next word.
        w_wr_nxt = w_rd_cur & r_mode;
        if ((r_o == NIJ) && !w_rd_cur) begin
          w_cnt_nxt = '0;
          w_o_nxt   = '0;
          if (r_kij == KIJ_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_kij_nxt   = r_kij + 4'd1;
            w_state_nxt = S_W_RD;
          end
        end else if (i_ofifo_valid && (r_o < NIJ)) begin
          w_rd_nxt = 1'b1;
          w_o_nxt  = r_o + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Build the instruction word for the cycle we are about to enter.
  always_comb begin
    w_inst_nxt     = DEFAULT_WORD;
    w_inst_nxt[34] = w_mode_nxt;
    w_inst_nxt[2]  = w_xrd_cur;
    case (w_state_nxt)
      S_W_RD: begin
        w_inst_nxt[19]   = 1'b0;
        w_inst_nxt[17:7] = w_waddr;
      end
      S_W_KL: begin
        w_inst_nxt[3] = 1'b1;
        w_inst_nxt[0] = 1'b1;
      end
      S_A_RD: begin
        w_inst_nxt[19]   = 1'b0;
        w_inst_nxt[17:7] = w_aaddr;
      end
      S_EXEC: begin
        w_inst_nxt[3] = 1'b1;
        w_inst_nxt[1] = 1'b1;
      end
      S_DRAIN: begin
        w_inst_nxt[6] = w_rd_nxt;
        if (w_wr_nxt) begin
          w_inst_nxt[33]    = w_acc;
          w_inst_nxt[32]    = 1'b0;
          w_inst_nxt[31]    = 1'b0;
          w_inst_nxt[30:20] = w_paddr;
        end
      end
      default: begin
      end
    endcase
  end

  // State, counters, latched configuration and the registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_o      <= '0;
      r_kij    <= '0;
      r_mode   <= 1'b0;
      r_w_base <= '0;
      r_a_base <= '0;
      r_p_base <= '0;
      r_inst   <= DEFAULT_WORD;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_o      <= w_o_nxt;
      r_kij    <= w_kij_nxt;
      r_mode   <= w_mode_nxt;
      r_w_base <= w_w_base_nxt;
      r_a_base <= w_a_base_nxt;
      r_p_base <= w_p_base_nxt;
      r_inst   <= w_inst_nxt;
      r_busy   <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign o_inst = r_inst;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_kij  = r_kij;

endmodule
